// File: rtl/aes_key_sched_pkg.sv
// =============================================================================
// aes_const / aes_wire : shared AES key-length constants and round-key types.
// Rev 1.0
// =============================================================================
`default_nettype none

package aes_const;
  localparam int NB = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    KL128 = 2'd0,
    KL192 = 2'd1,
    KL256 = 2'd2,
    KLBAD = 2'd3
  } key_len_t;

  function automatic logic [3:0] nk_of(input key_len_t kl);
    case (kl)
      KL192:   nk_of = 4'd6;
      KL256:   nk_of = 4'd8;
      default: nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_t kl);
    case (kl)
      KL192:   nr_of = 4'd12;
      KL256:   nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

package aes_wire;
  typedef logic [31:0]  rk_word_t;
  typedef logic [127:0] round_key_t;
endpackage

`default_nettype wire

// File: rtl/aes_key_sched_if.sv
// =============================================================================
// aes_key_sched_if : key-load, status and round-key read port of the scheduler.
// Rev 1.0
// =============================================================================
`default_nettype none

interface aes_key_sched_if;
  import aes_const::*;
  import aes_wire::*;

  logic       start;
  key_len_t   key_len;
  logic [255:0] key;
  logic [7:0] SBox [256];
  logic       ready;
  logic       busy;
  logic       done;
  logic       key_valid;
  logic       err;
  logic [3:0] rd_round;
  round_key_t rd_key;

  modport master (
    output start, key_len, key, SBox, rd_round,
    input  ready, busy, done, key_valid, err, rd_key
  );

  modport slave (
    input  start, key_len, key, SBox, rd_round,
    output ready, busy, done, key_valid, err, rd_key
  );
endinterface

`default_nettype wire

// File: rtl/aes_key_sched_sub_word.sv
// =============================================================================
// aes_sub_word : AES SubWord, four parallel S-box lookups on a 32-bit word.
// Rev 1.0
// =============================================================================
`default_nettype none

module aes_sub_word (
  input  logic [31:0] i_word,
  input  logic [7:0]  i_sbox [256],
  output logic [31:0] o_word
);
  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign o_word[8*g +: 8] = i_sbox[i_word[8*g +: 8]];
  end
endmodule

`default_nettype wire

// File: rtl/aes_key_sched.sv
// =============================================================================
// aes_key_sched : iterative AES-128/192/256 key expansion, one word per clock.
// Rev 1.0
// =============================================================================
`default_nettype none

module aes_key_sched
  import aes_const::*;
  import aes_wire::*;
(
  input  logic           clk,
  input  logic           rst_n,
  aes_key_sched_if.slave bus
);
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  key_len_t   r_kl;
  logic [5:0] r_idx;
  logic [2:0] r_pos;
  logic [7:0] r_rcon;
  logic       r_key_valid;
  logic       r_done;
  logic       r_err;
  rk_word_t   r_store [60];

  logic [3:0] w_nk;
  logic [3:0] w_nr;
  logic [5:0] w_last;
  logic [2:0] w_pos_max;
  rk_word_t   w_prev;
  rk_word_t   w_back;
  rk_word_t   w_sub_in;
  rk_word_t   w_sub_out;
  rk_word_t   w_t;
  rk_word_t   w_new;
  logic       w_accept;
  logic       w_bad;
  logic       w_wr;
  logic       w_last_wr;
  logic [5:0] w_rd_base;

  assign w_nk      = nk_of(r_kl);
  assign w_nr      = nr_of(r_kl);
  assign w_last    = 6'(NB * (32'(w_nr) + 1) - 1);
  assign w_pos_max = 3'(w_nk - 4'd1);
  assign w_prev    = r_store[r_idx - 6'd1];
  assign w_back    = r_store[r_idx - {2'b00, w_nk}];

  // One shared S-box instance: RotWord is applied ahead of it only at pos 0.
  assign w_sub_in = (r_pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .i_sbox (bus.SBox),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_t = w_prev;
    if (r_pos == 3'd0) begin
      w_t = w_sub_out ^ {r_rcon, 24'h0};
    end else if ((w_nk == 4'd8) && (r_pos == 3'd4)) begin
      w_t = w_sub_out;
    end
  end

  assign w_new = w_back ^ w_t;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bad       = 1'b0;
    w_wr        = 1'b0;
    w_last_wr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.key_len == KLBAD) begin
            w_bad = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        w_wr = 1'b1;
        if (r_idx == w_last) begin
          w_last_wr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_kl        <= KL128;
      r_idx       <= 6'd0;
      r_pos       <= 3'd0;
      r_rcon      <= RCON_INIT;
      r_key_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last_wr;
      r_err   <= w_bad;
      if (w_accept) begin
        r_kl        <= bus.key_len;
        r_idx       <= {2'b00, nk_of(bus.key_len)};
        r_pos       <= 3'd0;
        r_rcon      <= RCON_INIT;
        r_key_valid <= 1'b0;
      end else if (w_wr) begin
        r_idx <= r_idx + 6'd1;
        r_pos <= (r_pos == w_pos_max) ? 3'd0 : r_pos + 3'd1;
        if (r_pos == 3'd0) begin
          r_rcon <= xtime(r_rcon);
        end
        if (w_last_wr) begin
          r_key_valid <= 1'b1;
        end
      end
      if (w_bad) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  // Store is not reset; key_valid gates every read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 8; i++) begin
        r_store[i] <= bus.key[255-32*i -: 32];
      end
    end else if (w_wr) begin
      r_store[r_idx] <= w_new;
    end
  end

  assign w_rd_base = 6'(NB * 32'(bus.rd_round));

  always_comb begin
    bus.rd_key = '0;
    if (r_key_valid && (bus.rd_round <= w_nr)) begin
      bus.rd_key = {r_store[w_rd_base],         r_store[w_rd_base + 6'd1],
                    r_store[w_rd_base + 6'd2],  r_store[w_rd_base + 6'd3]};
    end
  end

  assign bus.ready     = (r_state == ST_IDLE);
  assign bus.busy      = (r_state == ST_EXPAND);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.key_valid = r_key_valid;
endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched.sv
// =============================================================================
// tb_aes_key_sched : directed FIPS-197 key-expansion vectors for aes_key_sched.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_aes_key_sched;
  import aes_const::*;

  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [255:0] C_KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] C_KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] C_KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C_R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] C_R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_R192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] C_R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  aes_key_sched_if bus ();

  aes_key_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input key_len_t kl, input logic [255:0] k);
    bus.start   = 1'b1;
    bus.key_len = kl;
    bus.key     = k;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%b exp=0", bus.key_valid); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.rd_key !== 128'h0) begin failures++; $display("FAIL reset_rd_key got=%h exp=0", bus.rd_key); end
  endtask

  task automatic test_aes128();
    int n;
    start_run(KL128, C_KEY128);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL a128_busy got=%b exp=1", bus.busy); end
    wait_done(n);
    checks++; if (n != 40) begin failures++; $display("FAIL a128_edges got=%0d exp=40", n); end
    checks++; if (bus.key_valid !== 1'b1 || bus.ready !== 1'b1) begin failures++; $display("FAIL a128_status kv=%b rdy=%b exp=1,1", bus.key_valid, bus.ready); end
    bus.rd_round = 4'd10; #1;
    checks++; if (bus.rd_key !== C_R128_10) begin failures++; $display("FAIL a128_r10 got=%h exp=%h", bus.rd_key, C_R128_10); end
    bus.rd_round = 4'd1; #1;
    checks++; if (bus.rd_key !== C_R128_1) begin failures++; $display("FAIL a128_r1 got=%h exp=%h", bus.rd_key, C_R128_1); end
    bus.rd_round = 4'd0; #1;
    checks++; if (bus.rd_key !== C_KEY128[255:128]) begin failures++; $display("FAIL a128_r0 got=%h exp=%h", bus.rd_key, C_KEY128[255:128]); end
    bus.rd_round = 4'd11; #1;
    checks++; if (bus.rd_key !== 128'h0) begin failures++; $display("FAIL a128_r11 got=%h exp=0", bus.rd_key); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL a128_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_aes192();
    int n;
    start_run(KL192, C_KEY192);
    wait_done(n);
    checks++; if (n != 46) begin failures++; $display("FAIL a192_edges got=%0d exp=46", n); end
    bus.rd_round = 4'd12; #1;
    checks++; if (bus.rd_key[31:0] !== 32'h01002202) begin failures++; $display("FAIL a192_w51 got=%h exp=01002202", bus.rd_key[31:0]); end
    bus.rd_round = 4'd1; #1;
    checks++; if (bus.rd_key !== C_R192_1) begin failures++; $display("FAIL a192_r1 got=%h exp=%h", bus.rd_key, C_R192_1); end
    bus.rd_round = 4'd13; #1;
    checks++; if (bus.rd_key !== 128'h0) begin failures++; $display("FAIL a192_r13 got=%h exp=0", bus.rd_key); end
  endtask

  task automatic test_aes256();
    int n;
    start_run(KL256, C_KEY256);
    wait_done(n);
    checks++; if (n != 52) begin failures++; $display("FAIL a256_edges got=%0d exp=52", n); end
    bus.rd_round = 4'd14; #1;
    checks++; if (bus.rd_key !== C_R256_14) begin failures++; $display("FAIL a256_r14 got=%h exp=%h", bus.rd_key, C_R256_14); end
    bus.rd_round = 4'd2; #1;
    checks++; if (bus.rd_key[127:96] !== 32'h9ba35411) begin failures++; $display("FAIL a256_w8 got=%h exp=9ba35411", bus.rd_key[127:96]); end
    bus.rd_round = 4'd1; #1;
    checks++; if (bus.rd_key !== C_KEY256[127:0]) begin failures++; $display("FAIL a256_r1 got=%h exp=%h", bus.rd_key, C_KEY256[127:0]); end
  endtask

  task automatic test_bad_len();
    bus.rd_round = 4'd0;
    start_run(KLBAD, C_KEY128);
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL bad_err got=%b exp=1", bus.err); end
    checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin failures++; $display("FAIL bad_state busy=%b rdy=%b exp=0,1", bus.busy, bus.ready); end
    checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL bad_key_valid got=%b exp=0", bus.key_valid); end
    checks++; if (bus.rd_key !== 128'h0) begin failures++; $display("FAIL bad_rd_key got=%h exp=0", bus.rd_key); end
    tick();
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL bad_err_pulse got=%b exp=0", bus.err); end
  endtask

  task automatic test_start_spam();
    int n;
    start_run(KL128, C_KEY128);
    bus.start   = 1'b1;
    bus.key_len = KL256;
    bus.key     = C_KEY256;
    wait_done(n);
    bus.start   = 1'b0;
    checks++; if (n != 40) begin failures++; $display("FAIL spam_edges got=%0d exp=40", n); end
    bus.rd_round = 4'd10; #1;
    checks++; if (bus.rd_key !== C_R128_10) begin failures++; $display("FAIL spam_r10 got=%h exp=%h", bus.rd_key, C_R128_10); end
    bus.rd_round = 4'd1; #1;
    checks++; if (bus.rd_key !== C_R128_1) begin failures++; $display("FAIL spam_r1 got=%h exp=%h", bus.rd_key, C_R128_1); end
  endtask

  task automatic test_back_to_back();
    int n;
    start_run(KL128, C_KEY128);
    wait_done(n);
    start_run(KL256, C_KEY256);
    checks++; if (bus.key_valid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept kv=%b busy=%b exp=0,1", bus.key_valid, bus.busy); end
    wait_done(n);
    checks++; if (n != 52) begin failures++; $display("FAIL b2b_edges got=%0d exp=52", n); end
    bus.rd_round = 4'd14; #1;
    checks++; if (bus.rd_key !== C_R256_14) begin failures++; $display("FAIL b2b_r14 got=%h exp=%h", bus.rd_key, C_R256_14); end
  endtask

  task automatic test_reset_mid();
    int n;
    start_run(KL256, C_KEY256);
    for (int i = 0; i < 20; i++) tick();
    bus.rd_round = 4'd0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_state rdy=%b busy=%b exp=1,0", bus.ready, bus.busy); end
    checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL rmid_key_valid got=%b exp=0", bus.key_valid); end
    checks++; if (bus.rd_key !== 128'h0) begin failures++; $display("FAIL rmid_rd_key got=%h exp=0", bus.rd_key); end
    tick();
    rst_n = 1'b1;
    tick();
    start_run(KL128, C_KEY128);
    wait_done(n);
    checks++; if (n != 40) begin failures++; $display("FAIL rmid_edges got=%0d exp=40", n); end
    bus.rd_round = 4'd10; #1;
    checks++; if (bus.rd_key !== C_R128_10) begin failures++; $display("FAIL rmid_r10 got=%h exp=%h", bus.rd_key, C_R128_10); end
    bus.rd_round = 4'd1; #1;
    checks++; if (bus.rd_key !== C_R128_1) begin failures++; $display("FAIL rmid_r1 got=%h exp=%h", bus.rd_key, C_R128_1); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.key_len  = KL128;
    bus.key      = '0;
    bus.rd_round = 4'd0;
    for (int i = 0; i < 256; i++) bus.SBox[i] = C_SBOX[2047-8*i -: 8];
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_aes128();
    test_aes192();
    test_aes256();
    test_bad_len();
    test_start_spam();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
